// File: rtl/key_event.sv
// Converts the debounced key level into one-cycle press / short / long / repeat
// commands for the game control logic, plus a held level while a press is tracked.
module key_event #(
    parameter int CLK_PER_MS = 50000,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic key_mark,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam int PRE_W  = $clog2(CLK_PER_MS);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
    localparam logic [MS_W-1:0]  LONG_LAST = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0]  REP_LAST  = MS_W'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_LONG    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic              press_q, press_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              held_q, held_d;
    logic              ms_tick;

    assign ms_tick = (pre_q == PRE_LAST);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        pre_d    = ms_tick ? '0 : pre_q + 1'b1;
        ms_d     = ms_q;
        press_d  = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            // A key held through reset must be seen low once before any press counts.
            ST_ARM: begin
                if (!key_mark) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (key_mark) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    pre_d   = '0;
                    ms_d    = '0;
                end
            end

            ST_PRESSED: begin
                // Release takes priority over a coincident long threshold.
                if (!key_mark) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end else if (ms_tick) begin
                    if (ms_q == LONG_LAST) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end

            ST_LONG: begin
                if (!key_mark) begin
                    state_d = ST_IDLE;
                end else if (ms_tick) begin
                    if (ms_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        ms_d     = '0;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_ARM;
            end
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ARM;
            pre_q    <= '0;
            ms_q     <= '0;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
            press_q  <= press_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign press_pulse  = press_q;
    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;
    assign held         = held_q;

endmodule
